mips_cpu_register_file_sb: RTL and testbench

Parametrised general-purpose register file for the MIPS CPU core: two combinational read ports, two write ports with a defined collision priority, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard. The scoreboard tracks registers awaiting a multi-cycle result, such as a load from a stalling memory bus. It sits between decode (reads, pending marks) and writeback (ports c and d). It replaces the fixed 32x32 file and keeps its register_v0 debug output.

---
 rtl/mips_cpu_pkg.sv | 14 +
 rtl/mips_cpu_reg_scoreboard.sv | 58 +++++
 rtl/mips_cpu_register_file_sb.sv | 102 ++++++++++
 tb/tb_mips_cpu_register_file_sb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU core: default register-file geometry
// and the architecturally special register addresses.
package mips_cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

  // $zero is hardwired to 0; $v0 holds function return values.
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_V0   = 5'd2;

endpackage

// File: rtl/mips_cpu_reg_scoreboard.sv
// Per-register pending-write scoreboard. A register is marked pending when
// decode issues a multi-cycle producer. It is cleared when writeback writes
// the register. A set on the same edge as a clear wins, because the set
// belongs to a newer request. pending_count is the registered popcount of the
// pending vector.
module mips_cpu_reg_scoreboard
  import mips_cpu_pkg::*;
#(
  parameter int  ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_c_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_c_addr_i,
  input  logic                  clr_d_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_d_addr_i,
  output logic [DEPTH-1:0]      pending_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [ADDR_WIDTH:0] count_q, count_d;

  // Next pending vector: clears first, then the set overrides. Register 0 is never pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_c_en_i) pend_d[clr_c_addr_i] = 1'b0;
    if (clr_d_en_i) pend_d[clr_d_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != ADDR_WIDTH'(REG_ZERO))) pend_d[set_addr_i] = 1'b1;
    pend_d[ADDR_WIDTH'(REG_ZERO)] = 1'b0;
  end

  // Popcount of the next pending vector, so count_q stays in step with pend_q.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
    end
  end

  // State update. Reset discards all outstanding requests.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign pending_o = pend_q;
  assign count_o   = count_q;

endmodule

// File: rtl/mips_cpu_register_file_sb.sv
// MIPS general-purpose register file with two combinational read ports and
// two write ports. Port D has priority over port C, both for storage and for
// the bypass. The file also has a pending-write scoreboard that drives
// read_busy_a/b for the hazard unit.
// Flow control: there is no valid/ready handshake. Every enabled write is
// accepted on its edge. Stalling is decided outside this block from read_busy.
module mips_cpu_register_file_sb
  import mips_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] register_v0,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic                  read_busy_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  read_busy_b,
  input  logic [ADDR_WIDTH-1:0] write_addr_c,
  input  logic                  write_enable_c,
  input  logic [DATA_WIDTH-1:0] write_data_c,
  input  logic [ADDR_WIDTH-1:0] write_addr_d,
  input  logic                  write_enable_d,
  input  logic [DATA_WIDTH-1:0] write_data_d,
  input  logic                  pend_set_enable,
  input  logic [ADDR_WIDTH-1:0] pend_set_addr,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] V0_ADDR   = ADDR_WIDTH'(REG_V0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic                  wr_c_ok, wr_d_ok;
  logic                  hit_c_a, hit_d_a, hit_c_b, hit_d_b;

  assign wr_c_ok = write_enable_c && (write_addr_c != ZERO_ADDR);
  assign wr_d_ok = write_enable_d && (write_addr_d != ZERO_ADDR);

  // Same-cycle write matches, used by the bypass and the busy masking.
  assign hit_c_a = write_enable_c && (write_addr_c == read_addr_a);
  assign hit_d_a = write_enable_d && (write_addr_d == read_addr_a);
  assign hit_c_b = write_enable_c && (write_addr_c == read_addr_b);
  assign hit_d_b = write_enable_d && (write_addr_d == read_addr_b);

  // Data array. D is written last, so D's data is stored when C and D write the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr_c_ok) regs_q[write_addr_c] <= write_data_c;
      if (wr_d_ok) regs_q[write_addr_d] <= write_data_d;
    end
  end

  mips_cpu_reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk_i        (clk),
    .reset_i      (reset),
    .set_en_i     (pend_set_enable),
    .set_addr_i   (pend_set_addr),
    .clr_c_en_i   (write_enable_c),
    .clr_c_addr_i (write_addr_c),
    .clr_d_en_i   (write_enable_d),
    .clr_d_addr_i (write_addr_d),
    .pending_o    (pending),
    .count_o      (pending_count)
  );

  // Read port A: stored value, optionally bypassed (D over C), zero for $zero and during reset.
  always_comb begin
    read_data_a = regs_q[read_addr_a];
    if (BYPASS && hit_c_a) read_data_a = write_data_c;
    if (BYPASS && hit_d_a) read_data_a = write_data_d;
    if (reset || (read_addr_a == ZERO_ADDR)) read_data_a = '0;
  end

  // Read port B: same selection as port A.
  always_comb begin
    read_data_b = regs_q[read_addr_b];
    if (BYPASS && hit_c_b) read_data_b = write_data_c;
    if (BYPASS && hit_d_b) read_data_b = write_data_d;
    if (reset || (read_addr_b == ZERO_ADDR)) read_data_b = '0;
  end

  // Busy flags: a write landing this cycle satisfies the pending request only when it is bypassed.
  always_comb begin
    read_busy_a = pending[read_addr_a] & ~(BYPASS & (hit_c_a | hit_d_a));
    read_busy_b = pending[read_addr_b] & ~(BYPASS & (hit_c_b | hit_d_b));
    if (reset || (read_addr_a == ZERO_ADDR)) read_busy_a = 1'b0;
    if (reset || (read_addr_b == ZERO_ADDR)) read_busy_b = 1'b0;
  end

  // Debug view of $v0, taken from storage with no bypass.
  assign register_v0 = reset ? '0 : regs_q[V0_ADDR];

endmodule

// File: tb/tb_mips_cpu_register_file_sb.sv
// Bench for mips_cpu_register_file_sb. Two instances share all inputs:
// inst 0 has BYPASS=1 and inst 1 has BYPASS=0. A reference model of the
// registers and pending bits produces the expected outputs of each cycle.
// Those values are pushed to exp_q when the inputs are driven, and popped
// when the outputs are sampled.
module tb_mips_cpu_register_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] ra, rb, wac, wad, psa;
  logic          wec, wed, pse;
  logic [DW-1:0] wdc, wdd;

  logic [DW-1:0] v0   [2];
  logic [DW-1:0] rd_a [2];
  logic [DW-1:0] rd_b [2];
  logic          bz_a [2];
  logic          bz_b [2];
  logic [AW:0]   cnt  [2];

  mips_cpu_register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .register_v0(v0[0]),
    .read_addr_a(ra), .read_data_a(rd_a[0]), .read_busy_a(bz_a[0]),
    .read_addr_b(rb), .read_data_b(rd_b[0]), .read_busy_b(bz_b[0]),
    .write_addr_c(wac), .write_enable_c(wec), .write_data_c(wdc),
    .write_addr_d(wad), .write_enable_d(wed), .write_data_d(wdd),
    .pend_set_enable(pse), .pend_set_addr(psa), .pending_count(cnt[0])
  );

  mips_cpu_register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset(reset), .register_v0(v0[1]),
    .read_addr_a(ra), .read_data_a(rd_a[1]), .read_busy_a(bz_a[1]),
    .read_addr_b(rb), .read_data_b(rd_b[1]), .read_busy_b(bz_b[1]),
    .write_addr_c(wac), .write_enable_c(wec), .write_data_c(wdc),
    .write_addr_d(wad), .write_enable_d(wed), .write_data_d(wdd),
    .pend_set_enable(pse), .pend_set_addr(psa), .pending_count(cnt[1])
  );

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] m_regs [DEPTH];
  logic          m_pend [DEPTH];
  logic [DW-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] addr, input bit byp);
    logic [DW-1:0] v;
    v = m_regs[addr];
    if (byp && wec && wac == addr) v = wdc;
    if (byp && wed && wad == addr) v = wdd;
    if (reset || addr == '0) v = '0;
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_bz(input logic [AW-1:0] addr, input bit byp);
    logic b;
    b = m_pend[addr];
    if (byp && ((wec && wac == addr) || (wed && wad == addr))) b = 1'b0;
    if (reset || addr == '0) b = 1'b0;
    return {{(DW-1){1'b0}}, b};
  endfunction

  function automatic logic [DW-1:0] exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    return DW'(n);
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wec && wac != '0) m_regs[wac] = wdc;
      if (wed && wad != '0) m_regs[wad] = wdd;
      if (wec) m_pend[wac] = 1'b0;
      if (wed) m_pend[wad] = 1'b0;
      if (pse && psa != '0) m_pend[psa] = 1'b1;
    end
  endtask

  function automatic logic [DW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // One clock cycle: inputs were set right after a negedge; check mid-low-phase, then take the edge.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(exp_rd(ra, k == 0));
      exp_q.push_back(exp_bz(ra, k == 0));
      exp_q.push_back(exp_rd(rb, k == 0));
      exp_q.push_back(exp_bz(rb, k == 0));
      exp_q.push_back(reset ? '0 : m_regs[2]);
      exp_q.push_back(exp_cnt());
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("c%0d i%0d rd_a", cyc, k), rd_a[k], pop_exp());
      check($sformatf("c%0d i%0d busy_a", cyc, k), {{(DW-1){1'b0}}, bz_a[k]}, pop_exp());
      check($sformatf("c%0d i%0d rd_b", cyc, k), rd_b[k], pop_exp());
      check($sformatf("c%0d i%0d busy_b", cyc, k), {{(DW-1){1'b0}}, bz_b[k]}, pop_exp());
      check($sformatf("c%0d i%0d v0", cyc, k), v0[k], pop_exp());
      check($sformatf("c%0d i%0d count", cyc, k), {{(DW-AW-1){1'b0}}, cnt[k]}, pop_exp());
    end
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
    reset = 1'b0;
    ra = a; rb = b;
    wec = 1'b0; wac = '0; wdc = '0;
    wed = 1'b0; wad = '0; wdd = '0;
    pse = 1'b0; psa = '0;
  endtask

  task automatic wr_c(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wec = 1'b1; wac = a; wdc = d;
  endtask

  task automatic wr_d(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wed = 1'b1; wad = a; wdd = d;
  endtask

  task automatic pend(input logic [AW-1:0] a);
    pse = 1'b1; psa = a;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    idle(5'd0, 5'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cycle();                                           // reset held: outputs forced to 0

    // Basic write / read, and $zero reads as 0.
    idle(5'd5, 5'd0); wr_c(5'd5, 32'h1234_5678); cycle();
    idle(5'd5, 5'd0); cycle();

    // C/D collision on 7; also load $v0.
    idle(5'd7, 5'd7); wr_c(5'd7, 32'hAAAA_0000); wr_d(5'd7, 32'h5555_FFFF); cycle();
    idle(5'd7, 5'd2); wr_d(5'd2, 32'h0000_CAFE); cycle();
    idle(5'd7, 5'd2); cycle();

    // Writes to $zero and pend on $zero are ignored.
    idle(5'd0, 5'd0); wr_d(5'd0, 32'hFFFF_FFFF); cycle();
    idle(5'd0, 5'd0); pend(5'd0); cycle();
    idle(5'd0, 5'd0); cycle();

    // Pend 9, then satisfy it with D.
    idle(5'd9, 5'd9); pend(5'd9); cycle();
    idle(5'd9, 5'd0); cycle();
    idle(5'd9, 5'd9); wr_d(5'd9, 32'h0000_0042); cycle();
    idle(5'd9, 5'd0); cycle();

    // Set and write-clear on the same edge: set wins, data still stored.
    idle(5'd9, 5'd0); pend(5'd9); wr_c(5'd9, 32'h0000_0010); cycle();
    idle(5'd9, 5'd9); cycle();

    // Several pending registers, then reset with a concurrent write.
    idle(5'd3, 5'd4); pend(5'd3); cycle();
    idle(5'd3, 5'd4); pend(5'd4); cycle();
    idle(5'd31, 5'd3); pend(5'd31); cycle();
    idle(5'd3, 5'd2); wr_c(5'd3, 32'hDEAD_BEEF); reset = 1'b1; cycle();
    idle(5'd3, 5'd31); cycle();
    idle(5'd2, 5'd4); cycle();

    // Random traffic biased toward a few addresses so collisions are common.
    for (int n = 0; n < 300; n++) begin
      idle(AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)));
      if ($urandom_range(0, 1) == 1) wr_c(AW'($urandom_range(0, 9)), $urandom());
      if ($urandom_range(0, 1) == 1) wr_d(AW'($urandom_range(0, 9)), $urandom());
      if ($urandom_range(0, 2) == 0) pend(AW'($urandom_range(0, 9)));
      if ($urandom_range(0, 49) == 0) reset = 1'b1;
      cycle();
    end

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
